pipe_stage_elastic: RTL and testbench

Parametrised, handshaked successor to the fixed-width stage registers between pipeline stages. It is used first at the MEM→WB boundary and later at every stage boundary. It carries a DATA_W-bit payload under a valid/ready protocol, with a 2-entry skid buffer so upstream `in_ready` is registered, a synchronous flush that inserts bubbles, and a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_stall_counter.sv | 25 ++
 rtl/pipe_stage_elastic.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: FSM states, the MEM->WB payload
// layout and default widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Field order matches the legacy MEM->WB register concatenation, MSB first.
    typedef struct packed {
        logic        reg_wr;
        logic [1:0]  wb_sel;
        logic [4:0]  waddr;
        logic [31:0] addr;
        logic [31:0] alu_result;
        logic [31:0] mem_out;
        logic [31:0] inst;
    } mem_wb_t;

    localparam int DEF_DATA_W      = $bits(mem_wb_t);
    localparam int DEF_STALL_CNT_W = 16;

    function automatic mem_wb_t unpack_mem_wb(input logic [DEF_DATA_W-1:0] raw);
        return mem_wb_t'(raw);
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating performance counter; clear wins over increment, never wraps.
module pipe_stall_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE_V = W'(1);
    localparam logic [W-1:0] MAX_V = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + ONE_V;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer
// (PIPE_SKID_EN), synchronous flush and a saturating stall counter.
//
// Handshake: a beat moves on a side only in a cycle where valid && ready are
// both high at the rising edge; the producer holds data stable while
// valid && !ready, and valid is never withdrawn before the transfer.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                STALL_CNT_W = DEF_STALL_CNT_W,
    parameter logic [DATA_W-1:0] RST_DATA    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_clr,
    output logic [1:0]             state_dbg
);

    state_e            state;
    logic [DATA_W-1:0] main_q;
    logic              out_valid_q;
    logic              in_xfer;
    logic              out_xfer;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;

    assign in_ready = in_ready_q;
`else
    // Without the skid entry the stage can only accept when its single slot
    // is empty or draining this very cycle.
    assign in_ready = out_ready || !out_valid_q;
`endif

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign state_dbg = state;

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            main_q      <= RST_DATA;
            skid_q      <= RST_DATA;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            main_q      <= RST_DATA;
            skid_q      <= RST_DATA;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state       <= ONE;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer) begin
                        state      <= FULL;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_xfer) begin
                        state      <= ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            main_q      <= RST_DATA;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            main_q      <= RST_DATA;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state       <= ONE;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    // An input beat here implies the held beat is leaving.
                    if (in_xfer) begin
                        main_q <= in_data;
                    end else if (out_xfer) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
`endif

    pipe_stall_counter #(
        .W (STALL_CNT_W)
    ) u_stall_counter (
        .clk (clk),
        .rst (rst),
        .clr (stall_clr),
        .inc (out_valid_q && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic; adapts to PIPE_SKID_EN.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int DW = DEF_DATA_W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [15:0]   stall_cnt;
    logic          stall_clr;
    logic [1:0]    state_dbg;

    logic          s_in_valid;
    logic          s_in_ready;
    logic [7:0]    s_in_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [7:0]    s_out_data;
    logic [3:0]    s_stall_cnt;
    logic          s_stall_clr;
    logic [1:0]    s_state_dbg;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    pipe_stage_elastic u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr),
        .state_dbg (state_dbg)
    );

    pipe_stage_elastic #(
        .DATA_W      (8),
        .STALL_CNT_W (4)
    ) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .flush     (1'b0),
        .stall_cnt (s_stall_cnt),
        .stall_clr (s_stall_clr),
        .state_dbg (s_state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until the beat is taken, bounded.
    task automatic accept_wait(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=no_accept required=accept", nm);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) tick();
        chk(nm, out_valid, 0);
    endtask

    // monitor: pops expected beat on every downstream transfer
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=%0h required=none", out_data);
            end else begin
                chk("out_order", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [DW-1:0] items[4];
        int idx;
        bit acc;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; stall_clr = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_stall_clr = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_state", state_dbg, EMPTY);
        rst = 1'b1;
        tick();

        // reset mid-stream, no clock edge
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 'hA; tick();
        in_data = 'hB; tick();
        in_valid = 1'b0; tick();
        chk("pre_rst_valid", out_valid, 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_stall", stall_cnt, 0);
        @(posedge clk); #1 rst = 1'b1;
        tick();

        // streaming 1..8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            exp_q.push_back(DW'(i));
            #1 chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_latency_valid", out_valid, 1);
            chk("stream_latency_data", out_data, DW'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_stall", stall_cnt, 0);

        // backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 'h11; exp_q.push_back('h11);
        tick();
        in_data = 'h22; exp_q.push_back('h22);
`ifdef PIPE_SKID_EN
        #1 chk("bp_skid_ready", in_ready, 1);
        tick();
        in_data = 'h33; exp_q.push_back('h33);
        #1 chk("bp_full_ready", in_ready, 0);
        chk("bp_full_state", state_dbg, FULL);
        tick(); tick();
`else
        #1 chk("bp_ready_low", in_ready, 0);
        tick(); tick(); tick();
`endif
        chk("bp_stall", stall_cnt, 3);
        out_ready = 1'b1;
        accept_wait("bp_accept");
`ifndef PIPE_SKID_EN
        in_valid = 1'b1; in_data = 'h33; exp_q.push_back('h33);
        accept_wait("bp_accept_33");
`endif
        drain("bp_drain");
        chk("bp_stall_hold", stall_cnt, 3);

        // flush, with out transfer in the flush cycle
        stall_clr = 1'b1; tick(); stall_clr = 1'b0;
        chk("stall_clr", stall_cnt, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 'h55; exp_q.push_back('h55);
        tick();
`ifdef PIPE_SKID_EN
        in_data = 'h66;
`else
        in_valid = 1'b0;
`endif
        tick();
        in_valid = 1'b1; in_data = 'h44; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_data", out_data, 0);
        chk("flush_stall", stall_cnt, 1);
        tick(); tick();
        chk("flush_no_44", out_valid, 0);

        // toggling out_ready stream
        items[0] = 'h71; items[1] = 'h72; items[2] = 'h73; items[3] = 'h74;
        for (int i = 0; i < 4; i++) exp_q.push_back(items[i]);
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            out_ready = c[0];
            in_valid = 1'b1; in_data = items[idx];
            #1;
`ifndef PIPE_SKID_EN
            if (out_valid) chk("tog_ready_follows", in_ready, out_ready);
`endif
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("tog_all_sent", idx, 4);
        drain("tog_drain");

        // saturation on 4-bit counter
        s_in_valid = 1'b1; s_in_data = 8'h5A; tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_15", s_stall_cnt, 15);
        s_stall_clr = 1'b1; tick();
        chk("sat_clr", s_stall_cnt, 0);
        s_stall_clr = 1'b0; tick();
        chk("sat_resume", s_stall_cnt, 1);

        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
